// File: rtl/coin_accumulator_if.sv
// Coin-acceptor bus: coin/cancel/vend strobes in, credit and refund results out.
// The accumulator attaches through the slave modport, the driving stage through master.
interface coin_accumulator_if #(
  parameter int unsigned PAID_W = 5
);
  logic              coin_valid;
  logic [1:0]        coin_type;
  logic              cancel;
  logic              vend_done;
  logic [PAID_W-1:0] paid;
  logic              coin_reject;
  logic              refund_valid;
  logic [PAID_W-1:0] refund_amt;
  logic              busy;

  modport master (
    output coin_valid, coin_type, cancel, vend_done,
    input  paid, coin_reject, refund_valid, refund_amt, busy
  );

  modport slave (
    input  coin_valid, coin_type, cancel, vend_done,
    output paid, coin_reject, refund_valid, refund_amt, busy
  );
endinterface

// File: rtl/coin_accumulator.sv
// Saturating coin credit accumulator with cancel refund and vend clear.
// Optional macro AUTO_REFUND_EN adds an inactivity timeout that refunds credit from COLLECT.
module coin_accumulator #(
  parameter int unsigned PAID_W      = 5,
  parameter int unsigned COIN0_VAL   = 1,
  parameter int unsigned COIN1_VAL   = 2,
  parameter int unsigned COIN2_VAL   = 5,
  parameter int unsigned COIN3_VAL   = 10,
  parameter int unsigned TIMEOUT_CYC = 100
) (
  input logic               i_clk,
  input logic               i_rst,
  coin_accumulator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCollect, StRefund} state_e;

  localparam logic [PAID_W:0] MAX_CREDIT = {1'b0, {PAID_W{1'b1}}};
  localparam logic [PAID_W:0] COIN0_W    = (PAID_W + 1)'(COIN0_VAL);
  localparam logic [PAID_W:0] COIN1_W    = (PAID_W + 1)'(COIN1_VAL);
  localparam logic [PAID_W:0] COIN2_W    = (PAID_W + 1)'(COIN2_VAL);
  localparam logic [PAID_W:0] COIN3_W    = (PAID_W + 1)'(COIN3_VAL);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be non-zero");
  end

  state_e            r_state, w_state_d;
  logic [PAID_W-1:0] r_paid, w_paid_d;
  logic [PAID_W-1:0] r_refund_amt, w_refund_amt_d;
  logic              r_coin_reject, w_coin_reject_d;
  logic              r_refund_valid, w_refund_valid_d;
  logic [PAID_W:0]   w_coin_val;
  logic [PAID_W:0]   w_sum;
  logic              w_accept;
  logic              w_timeout;

  always_comb begin
    w_coin_val = COIN0_W;
    unique case (bus.coin_type)
      2'd0: w_coin_val = COIN0_W;
      2'd1: w_coin_val = COIN1_W;
      2'd2: w_coin_val = COIN2_W;
      2'd3: w_coin_val = COIN3_W;
      default: w_coin_val = COIN0_W;
    endcase
  end

  // One extra bit so an overfill is detected instead of wrapping.
  assign w_sum = {1'b0, r_paid} + w_coin_val;

`ifdef AUTO_REFUND_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_cnt, w_cnt_d;

  assign w_timeout = (r_state == StCollect) && (r_cnt == CNT_MAX);

  always_comb begin
    w_cnt_d = '0;
    if (r_state == StCollect && w_state_d == StCollect && !w_accept) begin
      w_cnt_d = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_d        = r_state;
    w_paid_d         = r_paid;
    w_refund_amt_d   = r_refund_amt;
    w_coin_reject_d  = 1'b0;
    w_refund_valid_d = 1'b0;
    w_accept         = 1'b0;
    unique case (r_state)
      StIdle, StCollect: begin
        if (bus.vend_done) begin
          w_paid_d        = '0;
          w_state_d       = StIdle;
          w_coin_reject_d = bus.coin_valid;
        end else if (bus.cancel && r_state == StCollect) begin
          w_state_d        = StRefund;
          w_refund_amt_d   = r_paid;
          w_refund_valid_d = 1'b1;
          w_paid_d         = '0;
          w_coin_reject_d  = bus.coin_valid;
        end else if (bus.coin_valid) begin
          if (w_sum <= MAX_CREDIT) begin
            w_paid_d  = w_sum[PAID_W-1:0];
            w_state_d = StCollect;
            w_accept  = 1'b1;
          end else begin
            w_coin_reject_d = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_d        = StRefund;
          w_refund_amt_d   = r_paid;
          w_refund_valid_d = 1'b1;
          w_paid_d         = '0;
        end
      end
      StRefund: begin
        w_state_d       = StIdle;
        w_coin_reject_d = bus.coin_valid;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_paid         <= '0;
      r_refund_amt   <= '0;
      r_coin_reject  <= 1'b0;
      r_refund_valid <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_paid         <= w_paid_d;
      r_refund_amt   <= w_refund_amt_d;
      r_coin_reject  <= w_coin_reject_d;
      r_refund_valid <= w_refund_valid_d;
    end
  end

  assign bus.paid         = r_paid;
  assign bus.coin_reject  = r_coin_reject;
  assign bus.refund_valid = r_refund_valid;
  assign bus.refund_amt   = r_refund_amt;
  assign bus.busy         = (r_state != StIdle);

endmodule

// File: tb/tb_coin_accumulator.sv
// Scoreboard bench for coin_accumulator: directed steps queue expected outputs per cycle,
// a negedge monitor pops and compares them and flags any unexpected reject/refund pulse.
module tb_coin_accumulator;
  localparam int unsigned PAID_W = 5;

  typedef struct {
    int              cyc;
    logic [PAID_W-1:0] paid;
    logic            busy;
    logic            rej;
    logic            rv;
    logic [PAID_W-1:0] amt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  coin_accumulator_if #(.PAID_W(PAID_W)) bus ();

  coin_accumulator #(.PAID_W(PAID_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  task automatic chk(input string name, input int c, input logic [PAID_W-1:0] act,
                     input logic [PAID_W-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].cyc == cyc) begin
      mon_e = q.pop_front();
      chk("paid", mon_e.cyc, bus.paid, mon_e.paid);
      chk("busy", mon_e.cyc, PAID_W'(bus.busy), PAID_W'(mon_e.busy));
      chk("coin_reject", mon_e.cyc, PAID_W'(bus.coin_reject), PAID_W'(mon_e.rej));
      chk("refund_valid", mon_e.cyc, PAID_W'(bus.refund_valid), PAID_W'(mon_e.rv));
      chk("refund_amt", mon_e.cyc, bus.refund_amt, mon_e.amt);
    end else if (bus.coin_reject === 1'b1 || bus.refund_valid === 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_pulse cyc=%0d got rej=%b rv=%b want none", cyc,
               bus.coin_reject, bus.refund_valid);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected right after that edge.
  task automatic step(input logic r, input logic cv, input logic [1:0] ct, input logic cn,
                      input logic vd, input logic [PAID_W-1:0] ep, input logic eb,
                      input logic er, input logic erv, input logic [PAID_W-1:0] ea);
    exp_t e;
    rst            = r;
    bus.coin_valid = cv;
    bus.coin_type  = ct;
    bus.cancel     = cn;
    bus.vend_done  = vd;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.coin_valid = 1'b0;
    bus.coin_type  = 2'd0;
    bus.cancel     = 1'b0;
    bus.vend_done  = 1'b0;
    e.cyc  = cyc;
    e.paid = ep;
    e.busy = eb;
    e.rej  = er;
    e.rv   = erv;
    e.amt  = ea;
    q.push_back(e);
  endtask

  initial begin
    rst            = 1'b1;
    bus.coin_valid = 1'b0;
    bus.coin_type  = 2'd0;
    bus.cancel     = 1'b0;
    bus.vend_done  = 1'b0;
    //   rst cv ct cn vd | paid busy rej rv amt
    step(1, 0, 0, 0, 0,   0, 0, 0, 0,  0);
    step(0, 0, 0, 0, 0,   0, 0, 0, 0,  0);
    step(0, 1, 3, 0, 0,  10, 1, 0, 0,  0);
    step(0, 1, 2, 0, 0,  15, 1, 0, 0,  0);
    step(0, 1, 3, 0, 0,  25, 1, 0, 0,  0);
    step(0, 1, 3, 0, 0,  25, 1, 1, 0,  0);  // 35 overfills
    step(0, 1, 1, 0, 0,  27, 1, 0, 0,  0);
    step(0, 1, 1, 0, 0,  29, 1, 0, 0,  0);
    step(0, 1, 1, 0, 0,  31, 1, 0, 0,  0);  // exact fill
    step(0, 1, 0, 0, 0,  31, 1, 1, 0,  0);
    step(0, 0, 0, 0, 1,   0, 0, 0, 0,  0);  // vend clears
    step(0, 1, 3, 0, 0,  10, 1, 0, 0,  0);
    step(0, 1, 1, 0, 0,  12, 1, 0, 0,  0);
    step(0, 0, 0, 1, 0,   0, 1, 0, 1, 12);  // cancel -> refund
    step(0, 0, 0, 0, 0,   0, 0, 0, 0, 12);
    step(0, 0, 0, 1, 0,   0, 0, 0, 0, 12);  // cancel in idle ignored
    step(0, 1, 3, 0, 0,  10, 1, 0, 0, 12);
    step(0, 0, 0, 1, 0,   0, 1, 0, 1, 10);  // cancel held high
    step(0, 0, 0, 1, 0,   0, 0, 0, 0, 10);
    step(0, 0, 0, 1, 0,   0, 0, 0, 0, 10);
    step(0, 1, 3, 0, 0,  10, 1, 0, 0, 10);
    step(0, 0, 0, 1, 1,   0, 0, 0, 0, 10);  // vend beats cancel
    step(0, 1, 2, 0, 0,   5, 1, 0, 0, 10);
    step(0, 1, 1, 0, 0,   7, 1, 0, 0, 10);
    step(0, 1, 0, 1, 0,   0, 1, 1, 1,  7);  // coin+cancel
    step(0, 0, 0, 0, 0,   0, 0, 0, 0,  7);
    step(0, 1, 3, 0, 0,  10, 1, 0, 0,  7);
    step(0, 0, 0, 1, 0,   0, 1, 0, 1, 10);
    step(0, 1, 0, 0, 0,   0, 0, 1, 0, 10);  // coin during refund
    step(0, 1, 3, 0, 0,  10, 1, 0, 0, 10);
    step(0, 1, 1, 0, 1,   0, 0, 1, 0, 10);  // coin+vend
    step(0, 1, 2, 1, 0,   5, 1, 0, 0, 10);  // coin+cancel in idle accepted
    step(0, 0, 0, 1, 0,   0, 1, 0, 1,  5);
    step(1, 0, 0, 0, 0,   0, 0, 0, 0,  0);  // reset in refund cycle
    step(0, 0, 0, 0, 0,   0, 0, 0, 0,  0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
